hash_g_client: RTL and testbench

- Initiator side of the start/valid hash interface used by the pre-encrypt stage.
- Accepts a seed request from the encrypt controller, issues one SHA3-512 (Kyber G) operation, and waits for the digest.
- Captures the 512-bit result and returns it split into rho and sigma halves over a valid/ready response channel.
- Adds a watchdog timeout so a stalled hash core cannot hang the encrypt pipeline.

---
 rtl/hash_g_client.sv | 158 +++++++++++++++
 tb/tb_hash_g_client.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_g_client.sv
// Initiator for one SHA3-512 (Kyber G) operation: issue the seed, wait for the digest, return rho/sigma.
// Optional performance counters (last_latency, req_count) are built when HASH_CLIENT_PERF_EN is defined.
module hash_g_client #(
    parameter int KYBER_N        = 256,
    parameter int IN_WIDTH       = 2*KYBER_N,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IN_WIDTH-1:0]   req_data,
    output logic                  hash_start,
    output logic [IN_WIDTH-1:0]   hash_in,
    input  logic [2*KYBER_N-1:0]  hash_out,
    input  logic                  hash_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [KYBER_N-1:0]    rho,
    output logic [KYBER_N-1:0]    sigma,
    output logic                  timeout_err,
    output logic                  busy
`ifdef HASH_CLIENT_PERF_EN
    ,
    output logic [15:0]           last_latency,
    output logic [15:0]           req_count
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   hash_in_q, hash_in_d;
    logic [KYBER_N-1:0]    rho_q, rho_d;
    logic [KYBER_N-1:0]    sigma_q, sigma_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  accept;

`ifdef HASH_CLIENT_PERF_EN
    logic [15:0]           last_latency_q, last_latency_d;
    logic [15:0]           req_count_q, req_count_d;
`endif

    // req_ready is registered so it reads 0 while rst_n is held low.
    assign accept = req_valid && req_ready_q && (state_q == ST_IDLE);

    always_comb begin
        state_d       = state_q;
        hash_in_d     = hash_in_q;
        rho_d         = rho_q;
        sigma_d       = sigma_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`ifdef HASH_CLIENT_PERF_EN
        last_latency_d = last_latency_q;
        req_count_d    = req_count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hash_in_d = req_data;
                    state_d   = ST_ISSUE;
`ifdef HASH_CLIENT_PERF_EN
                    req_count_d = req_count_q + 16'd1;
`endif
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A digest arriving on the last allowed cycle beats the timeout.
                if (hash_valid) begin
                    rho_d   = hash_out[2*KYBER_N-1:KYBER_N];
                    sigma_d = hash_out[KYBER_N-1:0];
                    state_d = ST_RESP;
`ifdef HASH_CLIENT_PERF_EN
                    last_latency_d = 16'(cnt_q) + 16'd1;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    rho_d         = '0;
                    sigma_d       = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hash_in_q     <= '0;
            rho_q         <= '0;
            sigma_q       <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            req_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hash_in_q     <= hash_in_d;
            rho_q         <= rho_d;
            sigma_q       <= sigma_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            req_ready_q   <= req_ready_d;
        end
    end

`ifdef HASH_CLIENT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_latency_q <= '0;
            req_count_q    <= '0;
        end else begin
            last_latency_q <= last_latency_d;
            req_count_q    <= req_count_d;
        end
    end

    assign last_latency = last_latency_q;
    assign req_count    = req_count_q;
`endif

    assign req_ready   = req_ready_q;
    assign hash_start  = (state_q == ST_ISSUE);
    assign hash_in     = hash_in_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rho         = rho_q;
    assign sigma       = sigma_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hash_g_client.sv
// Self-checking bench for hash_g_client: vector table plus hand-written backpressure,
// spurious-valid and reset-in-WAIT sequences, with a delay-programmable echo core model.
module tb_hash_g_client;

    localparam int KN = 256;
    localparam int W  = 2*KN;
    localparam int TO = 8;

    typedef struct {
        logic [W-1:0] data;
        int           delay;     // 0 = core never answers
        bit           exp_to;
        bit           exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  req_data = '0;
    logic          req_ready, hash_start, rsp_valid, timeout_err, busy;
    logic [W-1:0]  hash_in, hash_out;
    logic          hash_valid;
    logic          core_valid = 1'b0;
    logic          spur_valid = 1'b0;
    logic [W-1:0]  core_out = '0;
    logic [W-1:0]  spur_data = '0;
    logic [KN-1:0] rho, sigma;
`ifdef HASH_CLIENT_PERF_EN
    logic [15:0]   last_latency, req_count;
`endif

    assign hash_valid = core_valid | spur_valid;
    assign hash_out   = spur_valid ? spur_data : core_out;

    always #5 clk = ~clk;

    hash_g_client #(.KYBER_N(KN), .IN_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .hash_start(hash_start), .hash_in(hash_in),
        .hash_out(hash_out), .hash_valid(hash_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rho(rho), .sigma(sigma),
        .timeout_err(timeout_err), .busy(busy)
`ifdef HASH_CLIENT_PERF_EN
        , .last_latency(last_latency), .req_count(req_count)
`endif
    );

    // Core model: echoes its operand core_delay cycles after the start pulse.
    int           core_delay = 1;
    int           pending = 0;
    logic [W-1:0] cap = '0;
    initial begin
        forever begin
            @(negedge clk);
            core_valid = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    core_valid = 1'b1;
                    core_out   = cap;
                end
            end
            if (hash_start && core_delay > 0) begin
                pending = core_delay;
                cap     = hash_in;
            end
        end
    end

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] sb_q[$];
    logic [15:0]  exp_req_count = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rsp_data();
        logic [W-1:0] exp;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got response with no expected entry, required 1 entry");
        end else begin
            exp = sb_q.pop_front();
            chk("rho", rho, exp[W-1:KN]);
            chk("sigma", sigma, exp[KN-1:0]);
        end
    endtask

    function automatic logic [W-1:0] rnd512();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W/32; i++) r = {r[W-33:0], $urandom()};
        return r;
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", req_ready, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int extra_starts;
        int hin_bad;
        wait_ready();
        core_delay = v.delay;
        req_valid  = 1'b1;
        req_data   = v.data;
        if (!v.exp_to) sb_q.push_back(v.data);
        exp_req_count = exp_req_count + 16'd1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("start_cycle1", hash_start, 1);
        chk("hash_in_latched", hash_in, v.data);
        cyc = 1;
        extra_starts = 0;
        hin_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (hash_start) extra_starts++;
            if (busy && hash_in !== v.data) hin_bad++;
        end while (busy && !rsp_valid && cyc < 40);
        chk("single_start", extra_starts, 0);
        chk("hash_in_stable", hin_bad, 0);
        chk("timeout_err", timeout_err, v.exp_err);
        if (v.exp_to) begin
            chk("timeout_cycle", cyc, TO + 2);
            chk("no_rsp", rsp_valid, 0);
            chk("idle_after_to", busy, 0);
            chk("rho_cleared", rho, 0);
            chk("sigma_cleared", sigma, 0);
        end else begin
            chk("rsp_cycle", cyc, v.delay + 2);
            chk("rsp_valid", rsp_valid, 1);
            chk_rsp_data();
`ifdef HASH_CLIENT_PERF_EN
            chk("last_latency", last_latency, v.delay);
`endif
            @(negedge clk);
            chk("rsp_drop", rsp_valid, 0);
            chk("ready_after_rsp", req_ready, 1);
        end
`ifdef HASH_CLIENT_PERF_EN
        chk("req_count", req_count, exp_req_count);
`endif
        $display("txn %0d: delay=%0d timeout=%0b cycles=%0d rsp_valid=%0b timeout_err=%0b",
                 idx, v.delay, v.exp_to, cyc, rsp_valid, timeout_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    vec_t          vecs[8];
    logic [W-1:0]  bp1, bp2;
    logic [KN-1:0] rho_s, sigma_s;
    int            bad;

    initial begin
        vecs[0] = '{data: {256'h0123456789ABCDEF_0011223344556677_8899AABBCCDDEEFF_FEDCBA9876543210,
                           256'h13579BDF02468ACE_DEADBEEFCAFEF00D_0F1E2D3C4B5A6978_A5A55A5A0123ABCD},
                    delay: 1, exp_to: 0, exp_err: 0};
        vecs[1] = '{data: rnd512(), delay: 3, exp_to: 0, exp_err: 0};
        vecs[2] = '{data: rnd512(), delay: TO, exp_to: 0, exp_err: 0};
        vecs[3] = '{data: rnd512(), delay: TO - 1, exp_to: 0, exp_err: 0};
        vecs[4] = '{data: rnd512(), delay: 0, exp_to: 1, exp_err: 1};
        vecs[5] = '{data: rnd512(), delay: 1, exp_to: 0, exp_err: 1};
        vecs[6] = '{data: rnd512(), delay: TO + 1, exp_to: 1, exp_err: 1};
        vecs[7] = '{data: rnd512(), delay: 2, exp_to: 0, exp_err: 1};

        // Power-on reset
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_hash_start", hash_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_rho", rho, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Response backpressure with a second request waiting
        bp1 = rnd512();
        bp2 = rnd512();
        wait_ready();
        rsp_ready  = 1'b0;
        core_delay = 1;
        req_valid  = 1'b1;
        req_data   = bp1;
        sb_q.push_back(bp1);
        exp_req_count = exp_req_count + 16'd1;
        @(negedge clk);
        req_data = bp2;
        chk("bp_start1", hash_start, 1);
        repeat (2) @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        rho_s   = rho;
        sigma_s = sigma;
        chk_rsp_data();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || hash_start || rho !== rho_s || sigma !== sigma_s) bad++;
        end
        chk("bp_hold_cycles_bad", bad, 0);
        chk("bp_rsp_still_valid", rsp_valid, 1);
        chk("bp_req_blocked", req_ready, 0);
        rsp_ready = 1'b1;
        sb_q.push_back(bp2);
        exp_req_count = exp_req_count + 16'd1;
        @(negedge clk);
        chk("bp_no_start_yet", hash_start, 0);
        chk("bp_ready_again", req_ready, 1);
        chk("bp_rsp_dropped", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_start2", hash_start, 1);
        chk("bp_hash_in2", hash_in, bp2);
        repeat (2) @(negedge clk);
        chk("bp_rsp2_valid", rsp_valid, 1);
        chk_rsp_data();
        @(negedge clk);
`ifdef HASH_CLIENT_PERF_EN
        chk("bp_req_count", req_count, exp_req_count);
`endif
        $display("txn bp: two requests under backpressure, rsp_valid held 10 cycles");

        // Spurious valid in IDLE
        rho_s     = rho;
        sigma_s   = sigma;
        spur_data = rnd512();
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("spur_rsp2", rsp_valid, 0);
        chk("spur_ready", req_ready, 1);
        chk("spur_rho", rho, rho_s);
        chk("spur_sigma", sigma, sigma_s);
`ifdef HASH_CLIENT_PERF_EN
        chk("spur_req_count", req_count, exp_req_count);
`endif
        $display("txn spur: hash_valid pulsed in IDLE, rsp_valid=%0b busy=%0b", rsp_valid, busy);

        // Reset while waiting on the core; its late digest must be ignored
        wait_ready();
        core_delay = 5;
        req_valid  = 1'b1;
        req_data   = rnd512();
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rw_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_req_ready", req_ready, 0);
        chk("rw_hash_start", hash_start, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_timeout_err", timeout_err, 0);
        chk("rw_rho", rho, 0);
        chk("rw_sigma", sigma, 0);
        chk("rw_hash_in", hash_in, 0);
`ifdef HASH_CLIENT_PERF_EN
        chk("rw_req_count", req_count, 0);
        chk("rw_last_latency", last_latency, 0);
`endif
        exp_req_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_ready_after", req_ready, 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        chk("rw_stray_ignored", bad, 0);
        $display("txn rst: reset in WAIT, stray digest ignored, busy=%0b", busy);

        run_vec(8, '{data: rnd512(), delay: 2, exp_to: 0, exp_err: 0});

        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
